// File: rtl/mux_scan_capture.sv
// Scan sequencer for an 8:1 mux: steps the select through 0..7, lets each value
// settle, samples the mux output into one bit of a byte and offers that byte on valid/ready.
module mux_scan_capture #(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_IN          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    output logic [2:0] sel,
    input  logic       y_in,
    output logic       busy,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LP_RELOAD   = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LP_SEL_LAST = 3'(N_IN - 1);

    // Handshake: data_out is transferred on the rising edge where data_valid && data_ready;
    // data_valid is only ever high in DONE and data_out is frozen for as long as it is high.

    state_t     r_state;
    logic [2:0] r_sel;
    logic [3:0] r_cnt;
    logic [7:0] r_capture;
    logic [7:0] r_data_out;
    logic       r_valid;
    logic       r_busy;
    logic [7:0] w_capture_next;

    always_comb begin
        w_capture_next        = r_capture;
        w_capture_next[r_sel] = y_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= 3'd0;
            r_cnt      <= 4'd0;
            r_capture  <= 8'h00;
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start || cont) begin
                        r_state   <= ST_SETTLE;
                        r_sel     <= 3'd0;
                        r_busy    <= 1'b1;
                        r_cnt     <= LP_RELOAD;
                        r_capture <= 8'h00;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_capture <= w_capture_next;
                    // The last select value is terminal: the byte is published instead of wrapping.
                    if (r_sel == LP_SEL_LAST) begin
                        r_state    <= ST_DONE;
                        r_data_out <= w_capture_next;
                        r_valid    <= 1'b1;
                    end else begin
                        r_sel   <= r_sel + 3'd1;
                        r_cnt   <= LP_RELOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (data_ready) begin
                        r_valid   <= 1'b0;
                        r_sel     <= 3'd0;
                        r_capture <= 8'h00;
                        if (cont) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= LP_RELOAD;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel         = r_sel;
    assign busy        = r_busy;
    assign data_out    = r_data_out;
    assign data_valid  = r_valid;
    assign o_dbg_state = r_state;

    a_hold_under_backpressure: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_valid && !data_ready) |=> (r_valid && $stable(r_data_out))
    );

    a_done_sel_terminal: assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_state == ST_DONE) |-> (r_sel == LP_SEL_LAST && r_valid)
    );

endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture: three instances (settle 2, 1, 15) driven by randomized scans,
// with a behavioural mux model, a byte scoreboard and timing expectations from the scan rules.
module tb_mux_scan_capture;

    localparam int N_DUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_s  [N_DUT];
    logic       start_s  [N_DUT];
    logic       cont_s   [N_DUT];
    logic       rdy_s    [N_DUT];
    logic       glitch_s [N_DUT];
    logic [7:0] mux_s    [N_DUT];
    logic [2:0] sel_s    [N_DUT];
    logic       busy_s   [N_DUT];
    logic       valid_s  [N_DUT];
    logic [7:0] dout_s   [N_DUT];
    logic [1:0] st_s     [N_DUT];

    logic [10:0] exp_q[$];
    logic [10:0] exp_e;
    int tests_run;
    int tests_failed;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        logic y;
        // Mux model: y is input[sel], optionally inverted to fake a settling glitch.
        assign y = mux_s[g][sel_s[g]] ^ glitch_s[g];
        mux_scan_capture #(
            .SETTLE_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
            .N_IN(8)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n_s[g]),
            .start(start_s[g]),
            .cont(cont_s[g]),
            .sel(sel_s[g]),
            .y_in(y),
            .busy(busy_s[g]),
            .data_out(dout_s[g]),
            .data_valid(valid_s[g]),
            .data_ready(rdy_s[g]),
            .o_dbg_state(st_s[g])
        );
    end

    function automatic int settle_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted byte must match the oldest expected one.
    always @(negedge clk) begin
        for (int g = 0; g < N_DUT; g++) begin
            if (rst_n_s[g] && valid_s[g] && rdy_s[g]) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_byte: dut%0d got %0h expected none", g, dout_s[g]);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("scoreboard_byte", {21'd0, g[2:0], dout_s[g]}, {21'd0, exp_e});
                end
            end
        end
    end

    task automatic start_scan(input int g, input logic [7:0] val);
        mux_s[g] = val;
        exp_q.push_back({g[2:0], val});
        start_s[g] = 1'b1;
        tick();
        start_s[g] = 1'b0;
        check("busy_after_start", busy_s[g], 1);
    endtask

    // Entered just after the edge that launched the scan; runs it through acceptance.
    task automatic wait_byte(input int g, input logic [7:0] val, input int stall,
                             input bit glitch_en, input bit noise);
        int  s;
        int  lim;
        int  n;
        bit  seen;
        logic cont_at;
        s    = settle_of(g);
        lim  = 8 * (s + 1);
        n    = 0;
        seen = 1'b0;
        rdy_s[g] = (stall == 0);
        while (!seen && n < lim + 4) begin
            glitch_s[g] = glitch_en && (((n + 1) % (s + 1)) != 0) && ($urandom_range(0, 1) == 1);
            if (noise) start_s[g] = ($urandom_range(0, 1) == 1);
            tick();
            n++;
            if (valid_s[g]) begin
                seen = 1'b1;
            end else begin
                check("sel_step", sel_s[g], ((n / (s + 1)) > 7) ? 7 : (n / (s + 1)));
                check("busy_in_scan", busy_s[g], 1);
            end
        end
        glitch_s[g] = 1'b0;
        check("scan_latency", seen ? (n + 1) : 0, lim + 1);
        if (!seen) begin
            start_s[g] = 1'b0;
            rdy_s[g]   = 1'b0;
            return;
        end
        check("data_out_first", dout_s[g], val);
        check("sel_done", sel_s[g], 7);
        check("busy_done", busy_s[g], 1);
        for (int i = 0; i < stall; i++) begin
            if (noise) start_s[g] = ($urandom_range(0, 1) == 1);
            tick();
            check("stall_valid", valid_s[g], 1);
            check("stall_data", dout_s[g], val);
            check("stall_sel", sel_s[g], 7);
        end
        start_s[g] = 1'b0;
        rdy_s[g]   = 1'b1;
        cont_at    = cont_s[g];
        tick();
        rdy_s[g] = 1'b0;
        check("valid_after_accept", valid_s[g], 0);
        check("sel_after_accept", sel_s[g], 0);
        check("busy_after_accept", busy_s[g], cont_at);
    endtask

    initial begin
        logic [7:0] v;
        int         s0;
        tests_run    = 0;
        tests_failed = 0;
        for (int g = 0; g < N_DUT; g++) begin
            rst_n_s[g]  = 1'b0;
            start_s[g]  = 1'b1;
            cont_s[g]   = 1'b0;
            rdy_s[g]    = 1'b0;
            glitch_s[g] = 1'b0;
            mux_s[g]    = 8'h00;
        end
        repeat (3) tick();
        for (int g = 0; g < N_DUT; g++) begin
            check("reset_sel", sel_s[g], 0);
            check("reset_busy", busy_s[g], 0);
            check("reset_valid", valid_s[g], 0);
            check("reset_data", dout_s[g], 0);
            start_s[g] = 1'b0;
            rst_n_s[g] = 1'b1;
        end
        repeat (3) tick();
        for (int g = 0; g < N_DUT; g++) begin
            check("idle_busy", busy_s[g], 0);
            check("idle_valid", valid_s[g], 0);
        end

        start_scan(0, 8'hB2);
        wait_byte(0, 8'hB2, 0, 1'b0, 1'b0);

        start_scan(0, 8'hFF);
        wait_byte(0, 8'hFF, 10, 1'b0, 1'b0);
        tick();
        check("idle_after_backpressure", busy_s[0], 0);

        // Continuous mode: second scan launches from the acceptance edge itself.
        mux_s[0] = 8'h00;
        exp_q.push_back({3'd0, 8'h00});
        cont_s[0] = 1'b1;
        tick();
        wait_byte(0, 8'h00, 0, 1'b0, 1'b0);
        mux_s[0] = 8'hFF;
        exp_q.push_back({3'd0, 8'hFF});
        cont_s[0] = 1'b0;
        wait_byte(0, 8'hFF, 0, 1'b0, 1'b0);

        // start and cont together, cont dropped mid-scan: exactly one byte.
        v = 8'($urandom);
        mux_s[0] = v;
        exp_q.push_back({3'd0, v});
        start_s[0] = 1'b1;
        cont_s[0]  = 1'b1;
        tick();
        start_s[0] = 1'b0;
        cont_s[0]  = 1'b0;
        wait_byte(0, v, 1, 1'b0, 1'b0);

        // Reset while sel == 4 discards the partial byte.
        s0 = settle_of(0);
        mux_s[0] = 8'($urandom);
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        repeat (4 * (s0 + 1)) tick();
        check("mid_scan_sel", sel_s[0], 4);
        rst_n_s[0] = 1'b0;
        tick();
        check("midreset_sel", sel_s[0], 0);
        check("midreset_busy", busy_s[0], 0);
        check("midreset_valid", valid_s[0], 0);
        check("midreset_data", dout_s[0], 0);
        rst_n_s[0] = 1'b1;
        tick();
        v = 8'($urandom);
        start_scan(0, v);
        wait_byte(0, v, 0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom);
            start_scan(0, v);
            wait_byte(0, v, $urandom_range(0, 4), 1'b1, 1'b1);
        end

        for (int g = 1; g < N_DUT; g++) begin
            start_scan(g, 8'h5A);
            wait_byte(g, 8'h5A, $urandom_range(0, 2), 1'b1, 1'b0);
        end

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_scan_capture.md
Name: mux_scan_capture

Overview:
- Sequencer that drives the 3-bit select of the 8:1 decoder/tristate-buffer mux and captures the mux output y for each select value.
- Each scan steps sel through 0..7, waits a programmable settle time at each step, then samples y into bit[sel] of a captured byte.
- The finished byte is presented on a valid/ready output handshake.
- Sits directly downstream of the mux: drives the mux select and consumes its single-bit output.

Parameters:
- SETTLE_CYCLES, 2, clock cycles sel is held stable before y is sampled; legal range 1..15.
- N_IN, 8, number of mux inputs; fixed at 8 (sel is 3 bits). Any other value is unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  one-shot request to begin a scan; sampled only in IDLE.
- cont  input  1  continuous mode: when 1, a new scan begins automatically after each accepted byte.
- sel  output  3  select lines driven to the mux s input.
- y_in  input  1  mux output y.
- busy  output  1  high from scan start until the byte is accepted.
- data_out  output  8  captured byte; bit k = y_in sampled while sel == k.
- data_valid  output  1  captured byte is available.
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready.

Behaviour:
- Reset (rst_n == 0 at a clk edge):
  - state = IDLE, sel = 0, busy = 0, data_valid = 0, data_out = 8'h00.
  - Settle counter and shift/capture register are cleared.
  - Reset has priority over every other input, including mid-scan; a partial byte is discarded.
- Registered outputs: all outputs are registered. No combinational path from any input to any output.
- IDLE:
  - Leave IDLE when start == 1 or cont == 1.
  - Next cycle: state = SETTLE, sel = 0, busy = 1, settle counter = SETTLE_CYCLES-1, capture register cleared.
- SETTLE:
  - Hold sel; decrement the counter each cycle.
  - When the counter == 0, go to SAMPLE.
- SAMPLE (1 cycle):
  - capture[sel] <= y_in.
  - If sel == 7, go to DONE.
  - Otherwise sel <= sel+1, counter reloads to SETTLE_CYCLES-1, return to SETTLE.
  - sel never wraps inside a scan; 7 is terminal.
- Timing per select value: exactly SETTLE_CYCLES cycles in SETTLE plus 1 cycle in SAMPLE.
- Scan latency: from the cycle start is sampled in IDLE to the first cycle data_valid = 1 is 8*(SETTLE_CYCLES+1)+1 cycles. With the default this is 25.
- DONE:
  - data_out = capture and data_valid = 1, both registered on entry.
  - data_out stays stable while data_valid == 1 && data_ready == 0.
  - sel is held at 7.
- Handshake completes (data_valid && data_ready in DONE):
  - data_valid <= 0 and sel <= 0.
  - If cont == 1: go directly to SETTLE (sel = 0), busy stays 1. This is a back-to-back scan with no IDLE cycle.
  - Otherwise: go to IDLE, busy <= 0.
- Ignored inputs:
  - start is ignored outside IDLE; there is no queuing.
  - data_ready is ignored when data_valid == 0.
- Simultaneous events:
  - start and cont both high in IDLE: one scan begins, behaving as if cont alone were high.
  - cont deasserted mid-scan: the current scan completes and its byte is delivered. The block then returns to IDLE after acceptance.
- y_in is sampled only in SAMPLE. Changes to y_in in SETTLE have no effect.
- data_out holds its last value after acceptance until the next DONE entry. Only data_valid qualifies it.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with start = 1 → sel = 0, busy = 0, data_valid = 0, data_out = 8'h00. Release with start = 0 → stays in IDLE.
- Single scan, mux inputs I = 8'b10110010, data_ready = 1, default parameters, pulse start:
  - sel steps 0..7, holding each value 3 cycles.
  - data_valid rises exactly 25 cycles after start is sampled, with data_out = 8'hB2.
  - data_valid stays high 1 cycle, then busy falls.
- Backpressure: I = 8'hFF, data_ready = 0 for 10 cycles after data_valid rises → data_out = 8'hFF stable and sel = 7 throughout. Assert data_ready → data_valid drops next cycle and the block returns to IDLE.
- Continuous mode: cont = 1, data_ready = 1, I changes from 8'h00 to 8'hFF between scans → two bytes, 8'h00 then 8'hFF. No IDLE cycle between scans, and busy stays 1.
- Reset mid-operation: assert rst_n = 0 while sel == 4 → next cycle sel = 0, busy = 0, data_valid = 0. A later start produces a full correct byte.
- Parameter sweep: SETTLE_CYCLES = 1 and 15 with I = 8'h5A → data_out = 8'h5A at latencies of 17 and 129 cycles respectively. A y_in glitch injected during SETTLE is not captured.
